// File: rtl/uart_rx_msg.sv
// UART receiver: 8 data bits LSB first, optional even parity, one stop bit.
// Each received byte is held on rx_byte with a valid/ack handshake.
// Framing, parity and overrun status travel with the byte.
module uart_rx_msg #(
  parameter int CLKS_PER_BIT = 100,
  parameter bit PARITY_EN    = 1'b0
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       rx_serial,
  input  logic       rx_ack,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE, S_BREAK
  } state_t;

  state_t        state_q, state_d;
  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    idx_q, idx_d;        // holds 0..8
  logic [7:0]    shift_q, shift_d;
  logic          perr_cap_q, perr_cap_d;
  logic          stop_q, stop_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          rx_valid_q, rx_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          parity_err_q, parity_err_d;
  logic          overrun_q, overrun_d;
  logic          busy_q, busy_d;
  logic          rxs;

  assign rxs = sync2_q;

  // Next-state logic: synchroniser, bit-timing FSM and output handshake
  always_comb begin
    sync1_d      = rx_serial;
    sync2_d      = sync1_q;
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    shift_d      = shift_q;
    perr_cap_d   = perr_cap_q;
    stop_d       = stop_q;
    rx_byte_d    = rx_byte_q;
    rx_valid_d   = rx_valid_q;
    frame_err_d  = frame_err_q;
    parity_err_d = parity_err_q;
    overrun_d    = overrun_q;

    // An ack only counts while there is something to acknowledge
    if (rx_ack && rx_valid_q) begin
      rx_valid_d = 1'b0;
      overrun_d  = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (!rxs) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        // Re-check the line mid start bit to reject glitches
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (!rxs) begin
            state_d    = S_DATA;
            idx_d      = 4'd0;
            perr_cap_d = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rxs, shift_q[7:1]};
          idx_d   = idx_q + 4'd1;
          if (idx_q == 4'd7) state_d = PARITY_EN ? S_PARITY : S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_PARITY: begin
        if (cnt_q == FULL_M1) begin
          cnt_d      = '0;
          perr_cap_d = (^shift_q) ^ rxs;
          state_d    = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          stop_d  = rxs;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        rx_byte_d    = shift_q;
        frame_err_d  = ~stop_q;
        parity_err_d = PARITY_EN ? perr_cap_q : 1'b0;
        rx_valid_d   = 1'b1;
        // Overwriting an unread, un-acked byte is an overrun
        if (rx_valid_q && !rx_ack) overrun_d = 1'b1;
        state_d = rxs ? S_IDLE : S_BREAK;
      end
      S_BREAK: begin
        // A held-low line must return high before the next start bit
        if (rxs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!nRst) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= 4'd0;
      shift_q      <= 8'h00;
      perr_cap_q   <= 1'b0;
      stop_q       <= 1'b0;
      rx_byte_q    <= 8'h00;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      perr_cap_q   <= perr_cap_d;
      stop_q       <= stop_d;
      rx_byte_q    <= rx_byte_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
      busy_q       <= busy_d;
    end
  end

  assign rx_byte    = rx_byte_q;
  assign rx_valid   = rx_valid_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_msg.sv
// Bench for uart_rx_msg: one receiver without parity, one with even parity.
// Expected bytes/flags are queued when a frame is driven and compared
// once the receiver has delivered it.
`timescale 1ns/1ps
module tb_uart_rx_msg;

  localparam int CPB = 16;
  localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1;  // no-parity receiver

  logic clk = 1'b0;
  logic nRst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rx0, ack0, valid0, fe0, pe0, ov0, busy0;
  logic [7:0] byte0;
  logic       rx1, ack1, valid1, fe1, pe1, ov1, busy1;
  logic [7:0] byte1;

  uart_rx_msg #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0)) u_dut0 (
    .clk(clk), .nRst(nRst), .rx_serial(rx0), .rx_ack(ack0),
    .rx_byte(byte0), .rx_valid(valid0), .frame_err(fe0),
    .parity_err(pe0), .overrun(ov0), .busy(busy0)
  );

  uart_rx_msg #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) u_dut1 (
    .clk(clk), .nRst(nRst), .rx_serial(rx1), .rx_ack(ack1),
    .rx_byte(byte1), .rx_valid(valid1), .frame_err(fe1),
    .parity_err(pe1), .overrun(ov1), .busy(busy1)
  );

  typedef struct packed {
    logic [7:0] b;
    logic       fe;
    logic       pe;
  } exp_t;

  exp_t sb_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int start_cyc0 = 0;
  int rise_cyc0 = -1000;
  logic prev_v0 = 1'b0;

  // Timestamp every rising edge of the no-parity receiver's rx_valid
  always @(negedge clk) begin
    if (valid0 && !prev_v0) rise_cyc0 <= cyc;
    prev_v0 <= valid0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_line(input bit sel, input logic v);
    if (sel) rx1 = v;
    else rx0 = v;
  endtask

  // Drive one frame; called at a negedge. Line is left at the stop level.
  task automatic send(input bit sel, input logic [7:0] b, input logic stop_bit, input logic par_bit);
    exp_t e;
    e.b  = b;
    e.fe = ~stop_bit;
    e.pe = sel ? ((^b) ^ par_bit) : 1'b0;
    sb_q.push_back(e);
    if (!sel) start_cyc0 = cyc;
    set_line(sel, 1'b0);
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      set_line(sel, b[i]);
      repeat (CPB) @(negedge clk);
    end
    if (sel) begin
      set_line(sel, par_bit);
      repeat (CPB) @(negedge clk);
    end
    set_line(sel, stop_bit);
    repeat (CPB) @(negedge clk);
  endtask

  task automatic pop_check(input bit sel, input string tag);
    exp_t e;
    int i;
    i = 0;
    while (i < 8 && !(sel ? valid1 : valid0)) begin
      @(negedge clk);
      i++;
    end
    check({tag, "_sb_nonempty"}, sb_q.size() != 0, 1);
    if (sb_q.size() == 0) return;
    e = sb_q.pop_front();
    $display("rx %s: dut%0d byte=%02h fe=%b pe=%b ov=%b (exp %02h fe=%b pe=%b)", tag, sel,
             sel ? byte1 : byte0, sel ? fe1 : fe0, sel ? pe1 : pe0, sel ? ov1 : ov0,
             e.b, e.fe, e.pe);
    check({tag, "_valid"}, sel ? valid1 : valid0, 1);
    check({tag, "_byte"}, sel ? byte1 : byte0, e.b);
    check({tag, "_ferr"}, sel ? fe1 : fe0, e.fe);
    check({tag, "_perr"}, sel ? pe1 : pe0, e.pe);
  endtask

  task automatic ack(input bit sel);
    if (sel) ack1 = 1'b1;
    else ack0 = 1'b1;
    @(negedge clk);
    ack0 = 1'b0;
    ack1 = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int t;
    rx0 = 1'b1; rx1 = 1'b1; ack0 = 1'b0; ack1 = 1'b0; nRst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_byte", byte0, 8'h00);
    check("rst_valid", valid0, 0);
    check("rst_ferr", fe0, 0);
    check("rst_perr", pe0, 0);
    check("rst_ov", ov0, 0);
    check("rst_busy", busy0, 0);
    check("rst_valid_p", valid1, 0);
    check("rst_busy_p", busy1, 0);
    nRst = 1'b1;
    repeat (2) @(negedge clk);

    // Basic reception and latency
    send(0, 8'hAB, 1'b1, 1'b0);
    pop_check(0, "ab");
    lat = rise_cyc0 - start_cyc0 - 1;
    $display("rx latency: %0d cycles (nominal %0d)", lat, LAT);
    check("lat_ab_in_range", (lat >= LAT - 1) && (lat <= LAT + 1), 1);
    check("ab_ov", ov0, 0);
    ack(0);
    check("ack_clr_valid", valid0, 0);
    repeat (4) @(negedge clk);
    check("idle_busy", busy0, 0);

    // Short low glitch must be rejected
    rx0 = 1'b0;
    repeat (4) @(negedge clk);
    check("glitch_busy_hi", busy0, 1);
    rx0 = 1'b1;
    repeat (14) @(negedge clk);
    check("glitch_busy_lo", busy0, 0);
    check("glitch_valid", valid0, 0);

    // Framing error followed by a held-low line
    send(0, 8'h6D, 1'b0, 1'b0);
    pop_check(0, "6d_ferr");
    repeat (24) @(negedge clk);
    check("break_busy", busy0, 1);
    rx0 = 1'b1;
    repeat (4) @(negedge clk);
    check("break_exit_busy", busy0, 0);
    ack(0);
    send(0, 8'h55, 1'b1, 1'b0);
    pop_check(0, "55");
    ack(0);
    repeat (2) @(negedge clk);

    // Overrun: two frames with no ack in between
    send(0, 8'hAB, 1'b1, 1'b0);
    pop_check(0, "ov1_ab");
    send(0, 8'h6D, 1'b1, 1'b0);
    pop_check(0, "ov1_6d");
    check("ov1_set", ov0, 1);
    ack(0);
    check("ov1_ack_valid", valid0, 0);
    check("ov1_ack_ov", ov0, 0);
    repeat (2) @(negedge clk);

    // Ack landing exactly in the completion cycle of the second frame
    send(0, 8'hAB, 1'b1, 1'b0);
    pop_check(0, "ov2_ab");
    t = cyc;
    fork
      send(0, 8'h6D, 1'b1, 1'b0);
      begin
        while (cyc != t + LAT) @(negedge clk);
        ack0 = 1'b1;
        @(negedge clk);
        ack0 = 1'b0;
      end
    join
    pop_check(0, "ov2_6d");
    check("ov2_no_ov", ov0, 0);
    ack(0);
    check("ov2_ack_valid", valid0, 0);
    repeat (2) @(negedge clk);

    // Reset in the middle of the data bits; remaining bits are all 1
    fork
      send(0, 8'hF0, 1'b1, 1'b0);
      begin
        repeat (85) @(negedge clk);
        check("mid_busy_before", busy0, 1);
        nRst = 1'b0;
        @(negedge clk);
        nRst = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", busy0, 0);
      end
    join
    void'(sb_q.pop_front());
    repeat (6) @(negedge clk);
    check("mid_rst_valid", valid0, 0);
    check("mid_rst_busy_end", busy0, 0);
    check("mid_rst_byte", byte0, 8'h00);

    // Even parity receiver
    send(1, 8'hAB, 1'b1, 1'b1);
    pop_check(1, "par_ok");
    ack(1);
    check("par_ack_valid", valid1, 0);
    send(1, 8'hAB, 1'b1, 1'b0);
    pop_check(1, "par_bad");
    ack(1);
    send(1, 8'h3C, 1'b1, 1'b0);
    pop_check(1, "par_3c");
    ack(1);
    check("dut0_quiet_valid", valid0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_msg.md
Name: uart_rx_msg

Overview:
- UART receiver that deserialises the tx_serial stream produced by the message-register/UART-transmitter pair.
- Presents each received byte on a held, handshaked output for the downstream message consumer.
- Used as the loopback/partner stage in the Reg+Tx integration and as the board-level receive path.
- Frame format: 8 data bits, LSB first, optional even parity, one stop bit.

Parameters:
- CLKS_PER_BIT, 100, clk cycles per UART bit (≥ 4; must equal the transmitter's divisor).
- PARITY_EN, 0, 1 = expect an even-parity bit between data bit 7 and the stop bit.

Ports:
- clk  in  1  system clock, rising edge.
- nRst  in  1  synchronous active-low reset.
- rx_serial  in  1  serial line (idle high), asynchronous to clk.
- rx_ack  in  1  consumer has taken rx_byte; clears rx_valid.
- rx_byte  out  8  last received byte, held until the next byte completes.
- rx_valid  out  1  rx_byte is unread.
- frame_err  out  1  stop bit sampled low for the byte in rx_byte.
- parity_err  out  1  parity mismatch for the byte in rx_byte (always 0 when PARITY_EN=0).
- overrun  out  1  a byte was overwritten while unread; sticky.
- busy  out  1  state != IDLE.

Behaviour:
- Synchronisation: rx_serial passes through a 2-FF synchroniser. Both flops reset to 1. All logic below uses the synchronised value (rxs).
- Reset (nRst low at a rising edge, including mid-frame):
  - state=IDLE; bit counter, bit index and shift register = 0.
  - rx_byte=8'h00; rx_valid, frame_err, parity_err, overrun, busy = 0.
- IDLE: rxs==0 → START, cnt=0.
- START: cnt increments each cycle. At cnt==CLKS_PER_BIT/2-1 (integer division), sample rxs:
  - 0 → DATA, cnt=0, idx=0.
  - 1 → glitch; return to IDLE, no output change.
- DATA: at cnt==CLKS_PER_BIT-1, sample rxs into shift register (shift right, new bit into [7]). Then cnt=0, idx++.
  - After idx 7: go to PARITY if PARITY_EN, else STOP.
- PARITY: at cnt==CLKS_PER_BIT-1, capture the parity bit. Error if (^shift ^ bit)!=0. Then → STOP.
- STOP: at cnt==CLKS_PER_BIT-1, sample the stop bit, then → DONE.
- DONE (exactly one cycle):
  - Load rx_byte from the shift register.
  - frame_err = ~stop_sample; parity_err = captured error.
  - Set rx_valid=1.
  - Next state: IDLE if rxs==1, else BREAK.
- BREAK: wait for rxs==1, then IDLE. A held-low line never re-triggers a start.
- Handshake:
  - rx_valid clears on the cycle after rx_ack==1 is sampled. rx_ack while rx_valid==0 is ignored.
  - rx_byte and error flags stay stable while rx_valid==1, except on overrun.
- Overrun:
  - DONE while rx_valid==1 and rx_ack==0: new byte and flags overwrite the old ones, rx_valid stays 1, overrun=1.
  - overrun clears with the next accepted rx_ack.
  - DONE with rx_ack==1 in the same cycle: new byte loaded, rx_valid stays 1, overrun not set.
- Latency: rx_valid rises 2 (synchroniser) + CLKS_PER_BIT/2 + (8+PARITY_EN+1)·CLKS_PER_BIT + 1 cycles after the first cycle rx_serial is low at a clk edge, ±1 cycle.
- Counters wrap only by explicit reset to 0. The idx width must hold 0..8.

Test Plan:
- Reset: hold nRst=0 for 2 clk with rx_serial=1 → all outputs 0, busy=0. Repeat with reset asserted mid-DATA → busy=0 next cycle; no rx_valid after the frame's remainder.
- CLKS_PER_BIT=16, PARITY_EN=0, send 8'hAB (line: 0,1,1,0,1,0,1,0,1,1) → rx_valid rises at latency ±1, rx_byte=8'hAB, frame_err=0. rx_ack pulse → rx_valid=0 next cycle.
- Glitch: rx_serial low for 4 cycles then high → busy returns to 0 by cycle ~12, rx_valid stays 0.
- Framing: send 8'h6D with stop bit 0, line then held low 40 cycles → rx_byte=8'h6D, frame_err=1. busy stays 1 until line high, then a following 8'h55 is received correctly.
- Overrun: send 8'hAB then 8'h6D with no rx_ack → rx_byte=8'h6D, overrun=1, rx_valid=1. rx_ack → rx_valid=0, overrun=0. Repeat with rx_ack asserted exactly in the DONE cycle → overrun=0, rx_valid=1, rx_byte=new byte.
- PARITY_EN=1: send 8'hAB with parity bit 1 (even) → parity_err=0. Send with parity bit 0 → parity_err=1, byte still delivered.
